// File: rtl/serial_add_ctrl_if.sv
// Request/result bundle for the bit-serial adder controller.
// The master drives the operands and the start request; the slave returns
// status and the registered result.
interface serial_add_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             carry;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, carry
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, carry
  );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full-adder cell, one bit per clock, LSB
// first. Operands are captured on an accepted start, the carry lives in a
// flip-flop between bit-steps, and completion is flagged by a one-cycle done.

// One-bit full adder; purely combinational.
module fa_ha (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic co_o
);
  assign s_o  = a_i ^ b_i ^ c_i;
  assign co_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  serial_add_ctrl_if.slave  bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             cy_q, cy_d;
  logic             carry_q, carry_d;
  logic             done_q, done_d;

  // Full-adder cell fed only from register outputs.
  logic fa_s, fa_co;
  fa_ha u_fa (
    .a_i  (sa_q[0]),
    .b_i  (sb_q[0]),
    .c_i  (cy_q),
    .s_o  (fa_s),
    .co_o (fa_co)
  );

  // New sum bit enters at the MSB; after WIDTH steps bit 0 sits at the LSB.
  // The widened shift keeps the expression legal for WIDTH == 1.
  logic [WIDTH-1:0] acc_shifted;
  assign acc_shifted = WIDTH'({fa_s, acc_q} >> 1);

  // Next-state logic for the controller and datapath.
  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    cy_d    = cy_q;
    carry_d = carry_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          sa_d    = bus.a;
          sb_d    = bus.b;
          cy_d    = bus.cin;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        acc_d = acc_shifted;
        sa_d  = sa_q >> 1;
        sb_d  = sb_q >> 1;
        cy_d  = fa_co;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_BIT) begin
          // Final bit: publish the result on the same edge it is formed.
          sum_d   = acc_shifted;
          carry_d = fa_co;
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers; reset abandons any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      cy_q    <= 1'b0;
      carry_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      cy_q    <= cy_d;
      carry_q <= carry_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy  = (state_q == S_RUN);
  assign bus.done  = done_q;
  assign bus.sum   = sum_q;
  assign bus.carry = carry_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl at WIDTH = 8, 1 and 13.
// Expected results are queued when a start is driven and popped on done.
module tb_serial_add_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  serial_add_ctrl_if #(.WIDTH(8))  if8  ();
  serial_add_ctrl_if #(.WIDTH(1))  if1  ();
  serial_add_ctrl_if #(.WIDTH(13)) if13 ();

  serial_add_ctrl #(.WIDTH(8))  u_dut8  (.clk(clk), .rst(rst), .bus(if8));
  serial_add_ctrl #(.WIDTH(1))  u_dut1  (.clk(clk), .rst(rst), .bus(if1));
  serial_add_ctrl #(.WIDTH(13)) u_dut13 (.clk(clk), .rst(rst), .bus(if13));

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] q8[$];
  logic [31:0] q1[$];
  logic [31:0] q13[$];
  logic [31:0] e8, e1, e13;
  logic [8:0]  prev_res8;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard: busy/done exclusivity every cycle, result check on every done.
  always @(negedge clk) begin
    if (!rst) begin
      check("excl8",  32'(if8.busy  & if8.done),  32'd0);
      check("excl1",  32'(if1.busy  & if1.done),  32'd0);
      check("excl13", 32'(if13.busy & if13.done), 32'd0);
      if (if8.done) begin
        if (q8.size() == 0) check("spurious_done8", 32'd1, 32'd0);
        else begin
          e8 = q8.pop_front();
          check("result8", 32'({if8.carry, if8.sum}), e8);
          $display("[%0t] w8  carry=%0d sum=%02h exp=%03h", $time, if8.carry, if8.sum, e8);
        end
      end
      if (if1.done) begin
        if (q1.size() == 0) check("spurious_done1", 32'd1, 32'd0);
        else begin
          e1 = q1.pop_front();
          check("result1", 32'({if1.carry, if1.sum}), e1);
          $display("[%0t] w1  carry=%0d sum=%0d exp=%0h", $time, if1.carry, if1.sum, e1);
        end
      end
      if (if13.done) begin
        if (q13.size() == 0) check("spurious_done13", 32'd1, 32'd0);
        else begin
          e13 = q13.pop_front();
          check("result13", 32'({if13.carry, if13.sum}), e13);
          $display("[%0t] w13 carry=%0d sum=%04h exp=%04h", $time, if13.carry, if13.sum, e13);
        end
      end
    end
  end

  // One WIDTH=8 operation with latency, busy length and result-hold checks.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c);
    int n;
    int busy_n;
    logic [31:0] e;
    e = 32'(a) + 32'(b) + 32'(c);
    @(posedge clk); #1;
    if8.start = 1'b1; if8.a = a; if8.b = b; if8.cin = c;
    q8.push_back(e);
    @(posedge clk); #1;
    if8.start = 1'b0; if8.a = 8'($urandom); if8.b = 8'($urandom); if8.cin = 1'b1;
    n = 0;
    busy_n = 0;
    do begin
      @(negedge clk);
      n++;
      if (if8.busy) begin
        busy_n++;
        check("hold8", 32'({if8.carry, if8.sum}), 32'(prev_res8));
      end
    end while (!if8.done && n < 40);
    check("done_seen8", 32'(if8.done), 32'd1);
    check("latency8", 32'(n - 1), 32'd8);
    check("busy_cycles8", 32'(busy_n), 32'd8);
    prev_res8 = e[8:0];
  endtask

  // One WIDTH=1 operation with latency check.
  task automatic op1(input logic a, input logic b, input logic c);
    int n;
    @(posedge clk); #1;
    if1.start = 1'b1; if1.a = a; if1.b = b; if1.cin = c;
    q1.push_back(32'(a) + 32'(b) + 32'(c));
    @(posedge clk); #1;
    if1.start = 1'b0; if1.a = ~a; if1.b = ~b; if1.cin = ~c;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!if1.done && n < 20);
    check("done_seen1", 32'(if1.done), 32'd1);
    check("latency1", 32'(n - 1), 32'd1);
  endtask

  initial begin
    int n, d1, d2;
    if8.start = 0;  if8.a = 0;  if8.b = 0;  if8.cin = 0;
    if1.start = 0;  if1.a = 0;  if1.b = 0;  if1.cin = 0;
    if13.start = 0; if13.a = 0; if13.b = 0; if13.cin = 0;
    prev_res8 = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_sum8",   32'(if8.sum),   32'd0);
    check("rst_carry8", 32'(if8.carry), 32'd0);
    check("rst_busy8",  32'(if8.busy),  32'd0);
    check("rst_done8",  32'(if8.done),  32'd0);
    rst = 1'b0;

    // Overflow into carry.
    op8(8'hFF, 8'h01, 1'b0);
    // Carry-in used; sum holds 8'h00 during RUN.
    op8(8'h5A, 8'h3C, 1'b1);

    // Start pulse during RUN must be ignored.
    fork
      op8(8'h12, 8'h34, 1'b0);
      begin
        #1;
        repeat (3) @(posedge clk);
        #1;
        if8.start = 1'b1; if8.a = 8'h11; if8.b = 8'h22; if8.cin = 1'b0;
        @(posedge clk); #1;
        if8.start = 1'b0;
      end
    join
    repeat (15) @(negedge clk);

    // Start held high: accepted again at T(WIDTH+2).
    @(posedge clk); #1;
    if8.start = 1'b1; if8.a = 8'h10; if8.b = 8'h20; if8.cin = 1'b0;
    q8.push_back(32'h30);
    q8.push_back(32'h30);
    n = 0; d1 = -1; d2 = -1;
    while (d2 < 0 && n < 60) begin
      @(negedge clk);
      n++;
      if (if8.done) begin
        if (d1 < 0) d1 = n;
        else begin
          d2 = n;
          if8.start = 1'b0;
        end
      end
    end
    if8.start = 1'b0;
    check("held_interval8", 32'(d2 - d1), 32'd10);
    prev_res8 = 9'h030;
    repeat (15) @(negedge clk);

    // Reset mid-RUN abandons the operation; no done may follow.
    @(posedge clk); #1;
    if8.start = 1'b1; if8.a = 8'hAA; if8.b = 8'h55; if8.cin = 1'b0;
    @(posedge clk); #1;
    if8.start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    check("arst_sum8",   32'(if8.sum),   32'd0);
    check("arst_carry8", 32'(if8.carry), 32'd0);
    check("arst_busy8",  32'(if8.busy),  32'd0);
    check("arst_done8",  32'(if8.done),  32'd0);
    @(negedge clk);
    rst = 1'b0;
    prev_res8 = '0;
    repeat (20) @(negedge clk);
    op8(8'h01, 8'h01, 1'b0);

    // WIDTH=1 exhaustive sweep.
    for (int i = 0; i < 8; i++) begin
      op1(i[2], i[1], i[0]);
    end

    // Random regression on WIDTH=8 and WIDTH=13 in parallel.
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          automatic int k = 0;
          repeat ($urandom_range(0, 3)) @(posedge clk);
          @(posedge clk); #1;
          if8.start = 1'b1;
          if8.a = 8'($urandom); if8.b = 8'($urandom); if8.cin = 1'($urandom);
          q8.push_back(32'(if8.a) + 32'(if8.b) + 32'(if8.cin));
          @(posedge clk); #1;
          if8.start = 1'b0; if8.a = 8'($urandom); if8.b = 8'($urandom);
          do begin
            @(negedge clk);
            k++;
          end while (!if8.done && k < 60);
          check("rnd_done8", 32'(if8.done), 32'd1);
        end
      end
      begin
        for (int j = 0; j < 1000; j++) begin
          automatic int m = 0;
          repeat ($urandom_range(0, 3)) @(posedge clk);
          @(posedge clk); #1;
          if13.start = 1'b1;
          if13.a = 13'($urandom); if13.b = 13'($urandom); if13.cin = 1'($urandom);
          q13.push_back(32'(if13.a) + 32'(if13.b) + 32'(if13.cin));
          @(posedge clk); #1;
          if13.start = 1'b0; if13.a = 13'($urandom); if13.b = 13'($urandom);
          do begin
            @(negedge clk);
            m++;
          end while (!if13.done && m < 60);
          check("rnd_done13", 32'(if13.done), 32'd1);
        end
      end
    join

    repeat (5) @(negedge clk);
    check("q8_drained",  32'(q8.size()),  32'd0);
    check("q1_drained",  32'(q1.size()),  32'd0);
    check("q13_drained", 32'(q13.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
